ram_access_sequencer: RTL and testbench
=======================================

RAM_ACCESS_SEQUENCER -- requirements
Module: ram_access_sequencer

Interface
REQ-001 The block SHALL have parameter RAH_CYCLES, default 1, giving the row-address hold clk cycles from nras fall to mux switch (legal 1..7).
REQ-002 The block SHALL have parameter PRE_CYCLES, default 2, giving the RAS precharge clk cycles after every access or refresh (legal 1..15).
REQ-003 The block SHALL have port clk, input, 1, master clock, rising-edge active.
REQ-004 The block SHALL have port nreset, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port nmreq, input, 1, Z80 /MREQ, asynchronous to clk.
REQ-006 The block SHALL have port nrfsh, input, 1, Z80 /RFSH, asynchronous to clk.
REQ-007 The block SHALL have port nsltsl3, input, 1, slot-3 select, active-low, asynchronous to clk.
REQ-008 The block SHALL have port nras, output, 1, DRAM /RAS.
REQ-009 The block SHALL have port mux, output, 1, address mux select (0 = row, 1 = column).
REQ-010 The block SHALL have port nmreqd, output, 1, delayed /MREQ feeding the CAS control stage.
REQ-011 The block SHALL have port nrfshd, output, 1, registered /RFSH feeding the CAS control stage.
REQ-012 The block SHALL have port ref_row, output, 7, refresh row address.
REQ-013 The block SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-014 nmreq, nrfsh and nsltsl3 SHALL each pass through a 2-flop synchronizer (s_nmreq, s_nrfsh, s_nsltsl3) before any use.
REQ-015 All outputs SHALL be registered, and each SHALL change on the same clk edge as the state transition that defines it.
REQ-016 nrfshd SHALL equal s_nrfsh delayed by one clk, independent of FSM state.
REQ-017 The FSM SHALL have exactly the states IDLE, RAS, COL, CAS, REF and PRE.
REQ-018 IDLE->RAS SHALL occur when s_nmreq=0, s_nsltsl3=0 and s_nrfsh=1; on that edge nras=0 and mux=0.
REQ-019 IDLE->REF SHALL occur when s_nmreq=0 and s_nrfsh=0, regardless of s_nsltsl3; on that edge nras=0.
REQ-020 Refresh SHALL take priority over an access when both conditions hold in the same cycle.
REQ-021 The FSM SHALL remain in RAS for RAH_CYCLES cycles, then enter COL with mux=1.
REQ-022 The FSM SHALL remain in COL for 1 cycle, then enter CAS with nmreqd=0.
REQ-023 In CAS, the FSM SHALL hold while s_nmreq=0.
REQ-024 In CAS, when s_nmreq=1 the FSM SHALL enter PRE with nras=1, mux=0 and nmreqd=1 on the same edge.
REQ-025 If s_nmreq=1 while in RAS or COL (aborted access), the FSM SHALL enter PRE directly, and nmreqd SHALL never assert.
REQ-026 In REF, the FSM SHALL hold while s_nmreq=0; mux stays 0 and nmreqd stays 1 throughout.
REQ-027 In REF, when s_nmreq=1 the FSM SHALL enter PRE with nras=1.
REQ-028 In PRE, nras SHALL stay 1 for PRE_CYCLES cycles, then the FSM returns to IDLE.
REQ-029 A request that becomes valid during PRE SHALL be evaluated on the first IDLE cycle and SHALL NOT be lost.
REQ-030 busy SHALL be 1 in every state except IDLE.

Reset
REQ-031 On nreset=0, state SHALL be IDLE, nras=1, mux=0, nmreqd=1, nrfshd=1, ref_row=0, busy=0, and all synchronizer flops SHALL read 1, immediately and independent of clk.
REQ-032 Reset asserted mid-access SHALL release nras/nmreqd at once, and the first access after reset deassertion SHALL follow REQ-018 normally.

Configuration
REQ-033 With RAM_REFRESH_COUNTER_EN defined, ref_row SHALL increment by 1 on each REF->PRE transition and SHALL wrap from 127 to 0.
REQ-034 Without RAM_REFRESH_COUNTER_EN, ref_row SHALL be constant 0 (the Z80 R register supplies the refresh row), and all other behaviour SHALL be unchanged.

Verification
REQ-035 Defaults, slot-3 read: nmreq=0, nsltsl3=0 -> nras=0 two clk after the edge that samples the inputs, mux=1 one cycle later, nmreqd=0 one cycle after that; nmreq=1 -> nras=1, mux=0, nmreqd=1 on one edge, then busy=0 after 2 PRE cycles.
REQ-036 Refresh: nmreq=0, nrfsh=0, nsltsl3=1 -> nras=0, mux=0, nmreqd=1, nrfshd=0; with RAM_REFRESH_COUNTER_EN, ref_row 0->1 on release; 128 refreshes -> ref_row=0.
REQ-037 Other slot: nmreq=0, nsltsl3=1, nrfsh=1 -> nras, mux and nmreqd stay 1 and busy stays 0.
REQ-038 Abort: nmreq pulsed low for 1 synchronized cycle with RAH_CYCLES=3 -> RAS->PRE, nmreqd never 0.
REQ-039 Back-to-back: new request during PRE -> nras held 1 for exactly PRE_CYCLES, then reasserts on the first IDLE cycle.
REQ-040 Reset mid-CAS: nreset=0 asynchronously -> nras=1, nmreqd=1, busy=0 before the next clk edge.

Source files
------------

// File: rtl/ram_access_sequencer.sv
// DRAM /RAS and address-mux sequencer for a Z80 slot-3 RAM. It synchronises the bus strobes, then runs the RAS/COL/CAS, refresh and precharge timing.
// Define RAM_REFRESH_COUNTER_EN to build an internal 7-bit refresh row counter; without it, ref_row is tied to 0.
module ram_access_sequencer #(
  parameter int RAH_CYCLES = 1,
  parameter int PRE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       nmreq,
  input  logic       nrfsh,
  input  logic       nsltsl3,
  output logic       nras,
  output logic       mux,
  output logic       nmreqd,
  output logic       nrfshd,
  output logic [6:0] ref_row,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, RAS, COL, CAS, REF, PRE} state_t;

  localparam logic [3:0] RAH_LOAD = 4'(RAH_CYCLES - 1);
  localparam logic [3:0] PRE_LOAD = 4'(PRE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic       nras_q, nras_d;
  logic       mux_q, mux_d;
  logic       nmreqd_q, nmreqd_d;
  logic       nrfshd_q, nrfshd_d;
  logic       busy_q, busy_d;
  logic       s_nmreq, s_nrfsh, s_nsltsl3;

  assign s_nmreq   = sync2_q[2];
  assign s_nrfsh   = sync2_q[1];
  assign s_nsltsl3 = sync2_q[0];

  always_comb begin
    sync1_d  = {nmreq, nrfsh, nsltsl3};
    sync2_d  = sync1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      // Refresh is checked first so it wins over a coincident slot-3 access.
      IDLE: begin
        if (!s_nmreq && !s_nrfsh) begin
          state_d = REF;
        end else if (!s_nmreq && !s_nsltsl3) begin
          state_d = RAS;
          cnt_d   = RAH_LOAD;
        end
      end
      RAS: begin
        if (s_nmreq) begin
          state_d = PRE;
          cnt_d   = PRE_LOAD;
        end else if (cnt_q == 4'd0) begin
          state_d = COL;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      COL: begin
        state_d = CAS;
        if (s_nmreq) begin
          state_d = PRE;
          cnt_d   = PRE_LOAD;
        end
      end
      CAS, REF: begin
        if (s_nmreq) begin
          state_d = PRE;
          cnt_d   = PRE_LOAD;
        end
      end
      PRE: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they switch on the transition edge.
    nras_d   = !(state_d inside {RAS, COL, CAS, REF});
    mux_d    = state_d inside {COL, CAS};
    nmreqd_d = (state_d != CAS);
    busy_d   = (state_d != IDLE);
    nrfshd_d = s_nrfsh;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      sync1_q  <= 3'b111;
      sync2_q  <= 3'b111;
      nras_q   <= 1'b1;
      mux_q    <= 1'b0;
      nmreqd_q <= 1'b1;
      nrfshd_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      nras_q   <= nras_d;
      mux_q    <= mux_d;
      nmreqd_q <= nmreqd_d;
      nrfshd_q <= nrfshd_d;
      busy_q   <= busy_d;
    end
  end

`ifdef RAM_REFRESH_COUNTER_EN
  logic [6:0] ref_row_q, ref_row_d;

  // Advance once per completed refresh; the 7-bit width gives the 127->0 wrap.
  always_comb begin
    ref_row_d = ref_row_q;
    if (state_q == REF && state_d == PRE) ref_row_d = ref_row_q + 7'd1;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) ref_row_q <= 7'd0;
    else         ref_row_q <= ref_row_d;
  end

  assign ref_row = ref_row_q;
`else
  assign ref_row = 7'd0;
`endif

  assign nras   = nras_q;
  assign mux    = mux_q;
  assign nmreqd = nmreqd_q;
  assign nrfshd = nrfshd_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Scoreboard bench for ram_access_sequencer: stimulus queues the output vectors it requires, and a negedge monitor compares each output change against them.
module tb_ram_access_sequencer;

  typedef struct packed {
    logic [11:0] v;
    logic [7:0]  gap;
  } exp_t;

  logic clk;
  logic nreset;
  logic nmreq, nrfsh, nsltsl3;
  logic nmreq3, nrfsh3, nsltsl33;
  logic nras, mux, nmreqd, nrfshd, busy;
  logic [6:0] ref_row;
  logic nras3, mux3, nmreqd3, nrfshd3, busy3;
  logic [6:0] ref_row3;

  exp_t q0[$];
  exp_t q1[$];
  int n_vec = 0;
  int n_fail = 0;
  int exp_row = 0;
  int cyc = 0, last0 = 0, last1 = 0;
  logic [11:0] prev0 = 'x, prev1 = 'x;

  ram_access_sequencer dut (
    .clk(clk), .nreset(nreset), .nmreq(nmreq), .nrfsh(nrfsh), .nsltsl3(nsltsl3),
    .nras(nras), .mux(mux), .nmreqd(nmreqd), .nrfshd(nrfshd), .ref_row(ref_row), .busy(busy)
  );

  ram_access_sequencer #(.RAH_CYCLES(3), .PRE_CYCLES(2)) dut3 (
    .clk(clk), .nreset(nreset), .nmreq(nmreq3), .nrfsh(nrfsh3), .nsltsl3(nsltsl33),
    .nras(nras3), .mux(mux3), .nmreqd(nmreqd3), .nrfshd(nrfshd3), .ref_row(ref_row3), .busy(busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Vector layout: {nras, mux, nmreqd, nrfshd, busy, ref_row}
  function automatic logic [11:0] ov(input logic a, input logic b, input logic c,
                                      input logic d, input logic e, input int row);
    return {a, b, c, d, e, 7'(row)};
  endfunction

  task automatic push0(input logic [11:0] v, input int gap);
    q0.push_back('{v: v, gap: 8'(gap)});
  endtask

  task automatic push1(input logic [11:0] v, input int gap);
    q1.push_back('{v: v, gap: 8'(gap)});
  endtask

  task automatic check(input int idx, input logic [11:0] o, input int gap);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (idx == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
    if (idx == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    n_vec++;
    if (!have) begin
      n_fail++;
      $display("FAIL dut%0d unexpected_change: got %h, no change required", idx, o);
    end else if (o !== e.v || (e.gap != 0 && gap != int'(e.gap))) begin
      n_fail++;
      $display("FAIL dut%0d vector: got %h after %0d cyc, required %h after %0d cyc (0=any)",
               idx, o, gap, e.v, e.gap);
    end
  endtask

  always @(negedge clk) begin
    logic [11:0] o0, o1;
    cyc++;
    o0 = {nras, mux, nmreqd, nrfshd, busy, ref_row};
    o1 = {nras3, mux3, nmreqd3, nrfshd3, busy3, ref_row3};
    if (o0 !== prev0) begin
      check(0, o0, cyc - last0);
      prev0 = o0;
      last0 = cyc;
    end
    if (o1 !== prev1) begin
      check(1, o1, cyc - last1);
      prev1 = o1;
      last1 = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bump_row();
`ifdef RAM_REFRESH_COUNTER_EN
    exp_row = (exp_row + 1) % 128;
`endif
  endtask

  task automatic do_read(input int hold);
    nmreq = 1'b0; nsltsl3 = 1'b0;
    push0(ov(0, 0, 1, 1, 1, exp_row), 0);
    push0(ov(0, 1, 1, 1, 1, exp_row), 1);
    push0(ov(0, 1, 0, 1, 1, exp_row), 1);
    tick(5 + hold);
    nmreq = 1'b1; nsltsl3 = 1'b1;
    push0(ov(1, 0, 1, 1, 1, exp_row), 0);
    push0(ov(1, 0, 1, 1, 0, exp_row), 2);
    tick(8);
  endtask

  task automatic do_refresh(input logic sl);
    nmreq = 1'b0; nrfsh = 1'b0; nsltsl3 = sl;
    push0(ov(0, 0, 1, 0, 1, exp_row), 0);
    tick(6);
    nmreq = 1'b1; nrfsh = 1'b1; nsltsl3 = 1'b1;
    bump_row();
    push0(ov(1, 0, 1, 1, 1, exp_row), 0);
    push0(ov(1, 0, 1, 1, 0, exp_row), 2);
    tick(8);
  endtask

  task automatic do_other_slot();
    nmreq = 1'b0; nsltsl3 = 1'b1; nrfsh = 1'b1;
    tick(8);
    nmreq = 1'b1;
    tick(6);
  endtask

  // Release CAS for one synchronised cycle; the new request lands during PRE.
  task automatic do_back_to_back();
    nmreq = 1'b0; nsltsl3 = 1'b0;
    push0(ov(0, 0, 1, 1, 1, exp_row), 0);
    push0(ov(0, 1, 1, 1, 1, exp_row), 1);
    push0(ov(0, 1, 0, 1, 1, exp_row), 1);
    tick(6);
    nmreq = 1'b1;
    tick(1);
    nmreq = 1'b0;
    push0(ov(1, 0, 1, 1, 1, exp_row), 0);
    push0(ov(1, 0, 1, 1, 0, exp_row), 2);
    push0(ov(0, 0, 1, 1, 1, exp_row), 1);
    push0(ov(0, 1, 1, 1, 1, exp_row), 1);
    push0(ov(0, 1, 0, 1, 1, exp_row), 1);
    tick(6);
    nmreq = 1'b1; nsltsl3 = 1'b1;
    push0(ov(1, 0, 1, 1, 1, exp_row), 0);
    push0(ov(1, 0, 1, 1, 0, exp_row), 2);
    tick(8);
  endtask

  task automatic do_reset_mid_cas();
    nmreq = 1'b0; nsltsl3 = 1'b0;
    push0(ov(0, 0, 1, 1, 1, exp_row), 0);
    push0(ov(0, 1, 1, 1, 1, exp_row), 1);
    push0(ov(0, 1, 0, 1, 1, exp_row), 1);
    tick(6);
    nreset = 1'b0; nmreq = 1'b1; nsltsl3 = 1'b1;
    exp_row = 0;
    push0(ov(1, 0, 1, 1, 0, 0), 1);
    tick(2);
    nreset = 1'b1;
    tick(2);
  endtask

  task automatic do_read3();
    nmreq3 = 1'b0; nsltsl33 = 1'b0;
    push1(ov(0, 0, 1, 1, 1, 0), 0);
    push1(ov(0, 1, 1, 1, 1, 0), 3);
    push1(ov(0, 1, 0, 1, 1, 0), 1);
    tick(9);
    nmreq3 = 1'b1; nsltsl33 = 1'b1;
    push1(ov(1, 0, 1, 1, 1, 0), 0);
    push1(ov(1, 0, 1, 1, 0, 0), 2);
    tick(8);
  endtask

  task automatic do_abort3();
    nmreq3 = 1'b0; nsltsl33 = 1'b0;
    push1(ov(0, 0, 1, 1, 1, 0), 0);
    tick(1);
    nmreq3 = 1'b1; nsltsl33 = 1'b1;
    push1(ov(1, 0, 1, 1, 1, 0), 1);
    push1(ov(1, 0, 1, 1, 0, 0), 2);
    tick(8);
  endtask

  initial begin
    exp_t e;
    nreset = 1'b1;
    nmreq = 1'b1; nrfsh = 1'b1; nsltsl3 = 1'b1;
    nmreq3 = 1'b1; nrfsh3 = 1'b1; nsltsl33 = 1'b1;
    push0(ov(1, 0, 1, 1, 0, 0), 0);
    push1(ov(1, 0, 1, 1, 0, 0), 0);
    #1 nreset = 1'b0;
    tick(3);
    nreset = 1'b1;
    tick(3);

    do_read(2);
    do_refresh(1'b1);
    do_refresh(1'b0);
    do_other_slot();
    do_back_to_back();
    do_reset_mid_cas();
    do_read(1);
    do_read3();
    do_abort3();
    for (int k = 0; k < 128; k++) do_refresh(1'b1);
    do_read(1);

    for (int k = 0; k < 50 && (q0.size() + q1.size()) > 0; k++) @(posedge clk);
    while (q0.size() > 0) begin
      e = q0.pop_front();
      n_vec++; n_fail++;
      $display("FAIL dut0 missing_change: got none, required %h", e.v);
    end
    while (q1.size() > 0) begin
      e = q1.pop_front();
      n_vec++; n_fail++;
      $display("FAIL dut1 missing_change: got none, required %h", e.v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
